// File: rtl/sfft_frame_reader_if.sv
// rtl/sfft_frame_reader_if.sv - bin stream bus from the frame reader to the fingerprinting logic
interface sfft_frame_reader_if #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
);
    logic [WIDTH-1:0] bin_data;
    logic [IDX_W-1:0] bin_index;
    logic             bin_valid;
    logic             bin_ready;
    logic             bin_last;

    modport master (
        output bin_data,
        output bin_index,
        output bin_valid,
        output bin_last,
        input  bin_ready
    );

    modport slave (
        input  bin_data,
        input  bin_index,
        input  bin_valid,
        input  bin_last,
        output bin_ready
    );
endinterface

// File: rtl/sfft_frame_reader.sv
// rtl/sfft_frame_reader.sv - captures an SFFT frame and streams |bin| values; peak tracking under SFFT_READER_PEAK_EN
module sfft_frame_reader #(
    parameter int NFFT   = 16,
    parameter int N_BINS = NFFT / 2,
    parameter int WIDTH  = 16,
    parameter int IDX_W  = $clog2(NFFT),
    parameter int OVR_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] SFFT_In [NFFT],
    input  logic                    InputValid,
    sfft_frame_reader_if.master     bin,
    output logic                    busy,
    output logic [OVR_W-1:0]        overrun_count,
    output logic [WIDTH-1:0]        peak_mag,
    output logic [IDX_W-1:0]        peak_idx,
    output logic                    peak_valid
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BINS - 1);

    logic [0:0]              state;
    logic [IDX_W-1:0]        rdIdx;
    logic signed [WIDTH-1:0] buffer [1 << IDX_W];
    logic [WIDTH-1:0]        absVal;
    logic                    xfer;
    logic                    lastXfer;
    logic                    capture;
    logic                    unusedHi;

    function automatic logic [WIDTH-1:0] absSat(input logic signed [WIDTH-1:0] x);
        if (!x[WIDTH-1])
            return $unsigned(x);
        else if (x == {1'b1, {(WIDTH-1){1'b0}}})
            return {1'b0, {(WIDTH-1){1'b1}}};
        else
            return $unsigned(-x);
    endfunction

    assign absVal   = absSat(buffer[rdIdx]);
    assign xfer     = bin.bin_valid & bin.bin_ready;
    assign lastXfer = xfer && (rdIdx == LAST_IDX);
    // A frame landing on the last-bin transfer is taken, not dropped.
    assign capture  = InputValid && ((state == IDLE) || lastXfer);

    assign busy          = (state == STREAM);
    assign bin.bin_valid = (state == STREAM);
    assign bin.bin_last  = (state == STREAM) && (rdIdx == LAST_IDX);
    assign bin.bin_index = rdIdx;
    assign bin.bin_data  = (state == STREAM) ? absVal : '0;

    always_comb begin
        unusedHi = 1'b0;
        for (int i = N_BINS; i < NFFT; i++)
            unusedHi = unusedHi ^ (^SFFT_In[i]);
    end

    always_ff @(posedge clk) begin
        if (capture)
            for (int i = 0; i < N_BINS; i++)
                buffer[i] <= SFFT_In[i];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            rdIdx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (InputValid) begin
                        state <= STREAM;
                        rdIdx <= '0;
                    end
                end
                default: begin
                    if (lastXfer) begin
                        state <= InputValid ? STREAM : IDLE;
                        rdIdx <= '0;
                    end else if (xfer) begin
                        rdIdx <= rdIdx + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            overrun_count <= '0;
        else if (InputValid && (state == STREAM) && !lastXfer && (overrun_count != '1))
            overrun_count <= overrun_count + 1'b1;
    end

`ifdef SFFT_READER_PEAK_EN
    logic [WIDTH-1:0] runMax;
    logic [IDX_W-1:0] runIdx;
    logic             newMax;

    // Strict compare keeps the lowest index on ties; bin 0 always seeds.
    assign newMax = (rdIdx == '0) || (absVal > runMax);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            runMax     <= '0;
            runIdx     <= '0;
            peak_mag   <= '0;
            peak_idx   <= '0;
            peak_valid <= 1'b0;
        end else begin
            peak_valid <= lastXfer;
            if (xfer && newMax) begin
                runMax <= absVal;
                runIdx <= rdIdx;
            end
            if (lastXfer) begin
                peak_mag <= newMax ? absVal : runMax;
                peak_idx <= newMax ? rdIdx : runIdx;
            end
        end
    end
`else
    assign peak_mag   = '0;
    assign peak_idx   = '0;
    assign peak_valid = 1'b0;
`endif

endmodule

// File: tb/tb_sfft_frame_reader.sv
// tb/tb_sfft_frame_reader.sv - scoreboard bench for sfft_frame_reader
`timescale 1ns/1ps
module tb_sfft_frame_reader;
    typedef struct {
        int data;
        int idx;
        bit last;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset;
    logic signed [15:0]  sfftIn [16];
    logic                InputValid;
    logic                ready;
    logic                busy, busy2;
    logic [7:0]          overrun_count;
    logic [1:0]          ovr2;
    logic [15:0]         peak_mag, pm2;
    logic [3:0]          peak_idx, pi2;
    logic                peak_valid, pv2;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   xfers = 0;
    int   peakPulses = 0;
    bit   prevPeak = 1'b0;
    int   expPeakMag, expPeakIdx;

    int frameA[8] = '{5, -3, 0, 100, -100, 7, -32768, 1};
    int frameB[8] = '{-1, 2, -3, 4, -5, 6, -7, 8};
    int frameC[8] = '{9, -9, 9, 0, 0, 0, 0, 0};

    sfft_frame_reader_if #(.WIDTH(16), .IDX_W(4)) bus  ();
    sfft_frame_reader_if #(.WIDTH(16), .IDX_W(4)) bus2 ();
    assign bus.bin_ready  = ready;
    assign bus2.bin_ready = ready;

    sfft_frame_reader #(.NFFT(16), .N_BINS(8), .WIDTH(16), .IDX_W(4), .OVR_W(8)) dut (
        .clk(clk), .reset(reset), .SFFT_In(sfftIn), .InputValid(InputValid), .bin(bus),
        .busy(busy), .overrun_count(overrun_count), .peak_mag(peak_mag),
        .peak_idx(peak_idx), .peak_valid(peak_valid)
    );

    sfft_frame_reader #(.NFFT(16), .N_BINS(8), .WIDTH(16), .IDX_W(4), .OVR_W(2)) dut2 (
        .clk(clk), .reset(reset), .SFFT_In(sfftIn), .InputValid(InputValid), .bin(bus2),
        .busy(busy2), .overrun_count(ovr2), .peak_mag(pm2),
        .peak_idx(pi2), .peak_valid(pv2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int absSat(input int x);
        if (x == -32768) return 32767;
        return (x < 0) ? -x : x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic loadFrame(input int f[8]);
        for (int i = 0; i < 16; i++)
            sfftIn[i] = (i < 8) ? 16'(f[i]) : 16'sh7abc;
    endtask

    task automatic pushFrame(input int f[8]);
        int m, mi, a;
        m = 0; mi = 0;
        for (int i = 0; i < 8; i++) begin
            a = absSat(f[i]);
            sb.push_back('{a, i, (i == 7)});
            if (i == 0 || a > m) begin
                m = a; mi = i;
            end
        end
        expPeakMag = m;
        expPeakIdx = mi;
    endtask

    task automatic waitIdle(input int budget, output int n);
        n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic waitIdx(input int target);
        for (int n = 0; n < 50; n++) begin
            if (bus.bin_valid && bus.bin_index == 4'(target)) break;
            step();
        end
        chk("wait_idx", bus.bin_index, target);
    endtask

    task automatic checkPeak(input int p0, input int frames);
`ifdef SFFT_READER_PEAK_EN
        chk("peak_pulses", peakPulses - p0, frames);
        chk("peak_mag", peak_mag, expPeakMag);
        chk("peak_idx", peak_idx, expPeakIdx);
`else
        chk("peak_pulses", peakPulses - p0, 0 * frames);
        chk("peak_mag", peak_mag, 0);
        chk("peak_idx", peak_idx, 0);
`endif
    endtask

    // Every valid cycle is checked against the scoreboard head, so stalls must hold.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.bin_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", bus.bin_valid, 0);
                end else begin
                    chk("bin_data", bus.bin_data, sb[0].data);
                    chk("bin_index", bus.bin_index, sb[0].idx);
                    chk("bin_last", bus.bin_last, sb[0].last);
                    if (ready) begin
                        void'(sb.pop_front());
                        xfers++;
                    end
                end
            end
            if (peak_valid) begin
                peakPulses++;
                chk("peak_width", prevPeak, 0);
            end
            prevPeak = peak_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, x0, p0;
        reset = 1'b0;
        ready = 1'b0;
        InputValid = 1'b0;
        loadFrame(frameB);
        repeat (3) step();
        chk("rst_valid", bus.bin_valid, 0);
        chk("rst_last", bus.bin_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_index", bus.bin_index, 0);
        chk("rst_data", bus.bin_data, 0);
        chk("rst_ovr", overrun_count, 0);
        chk("rst_peak_valid", peak_valid, 0);
        reset = 1'b1;
        repeat (2) step();

        // Back-to-back streaming with the sink always ready
        ready = 1'b1;
        p0 = peakPulses; x0 = xfers;
        loadFrame(frameA); pushFrame(frameA);
        InputValid = 1'b1; step(); InputValid = 1'b0;
        chk("first_valid", bus.bin_valid, 1);
        chk("first_index", bus.bin_index, 0);
        waitIdle(50, n);
        chk("stream_cycles", n, 8);
        chk("xfers1", xfers - x0, 8);
        repeat (2) step();
        checkPeak(p0, 1);

        // Stalled sink: pattern 1,0,0
        p0 = peakPulses; x0 = xfers;
        loadFrame(frameA); pushFrame(frameA);
        InputValid = 1'b1; step(); InputValid = 1'b0;
        for (int k = 0; k < 100 && busy; k++) begin
            ready = (k % 3 == 0);
            step();
        end
        chk("idle2", busy, 0);
        chk("xfers2", xfers - x0, 8);
        chk("sb_empty2", sb.size(), 0);
        ready = 1'b1;
        repeat (2) step();
        checkPeak(p0, 1);

        // Overruns: held pulse then isolated pulses, buffer must keep frame A
        ready = 1'b0;
        p0 = peakPulses; x0 = xfers;
        loadFrame(frameA); pushFrame(frameA);
        InputValid = 1'b1; step();
        loadFrame(frameB);
        step(); step();
        InputValid = 1'b0; step();
        InputValid = 1'b1; step();
        InputValid = 1'b0; step();
        chk("ovr3", overrun_count, 3);
        chk("ovr3_w2", ovr2, 3);
        repeat (2) begin
            InputValid = 1'b1; step();
            InputValid = 1'b0; step();
        end
        chk("ovr5", overrun_count, 5);
        chk("ovr5_sat", ovr2, 3);
        ready = 1'b1;
        waitIdle(50, n);
        chk("xfers3", xfers - x0, 8);
        repeat (2) step();
        checkPeak(p0, 1);

        // New frame arriving on the last-bin transfer, then tie frame peak
        p0 = peakPulses; x0 = xfers;
        loadFrame(frameA); pushFrame(frameA);
        InputValid = 1'b1; step(); InputValid = 1'b0;
        waitIdx(7);
        loadFrame(frameC); pushFrame(frameC);
        InputValid = 1'b1; step(); InputValid = 1'b0;
        chk("b2b_valid", bus.bin_valid, 1);
        chk("b2b_index", bus.bin_index, 0);
        chk("b2b_ovr", overrun_count, 5);
        waitIdle(50, n);
        chk("xfers4", xfers - x0, 16);
        repeat (2) step();
        checkPeak(p0, 2);

        // Asynchronous reset mid-stream
        p0 = peakPulses;
        loadFrame(frameA); pushFrame(frameA);
        InputValid = 1'b1; step(); InputValid = 1'b0;
        waitIdx(4);
        #1 reset = 1'b0;
        #1;
        chk("arst_valid", bus.bin_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_index", bus.bin_index, 0);
        chk("arst_data", bus.bin_data, 0);
        chk("arst_ovr", overrun_count, 0);
        sb.delete();
        repeat (2) step();
        reset = 1'b1;
        repeat (10) step();
        chk("post_rst_idle", busy, 0);
        chk("post_rst_pulses", peakPulses - p0, 0);
        chk("post_rst_peak", peak_mag, 0);

        // Recovery frame
        p0 = peakPulses; x0 = xfers;
        loadFrame(frameA); pushFrame(frameA);
        InputValid = 1'b1; step(); InputValid = 1'b0;
        waitIdle(50, n);
        chk("xfers6", xfers - x0, 8);
        repeat (2) step();
        checkPeak(p0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
